// File: rtl/block_scan_reader.sv
// Block-major frame reader: fetches fator x fator tiles from a single-port memory as a stream.
// Define BLOCK_SCAN_PAD_EN to emit partial edge tiles with clamped (edge-replicated) coordinates.
module block_scan_reader #(
    parameter int unsigned largura = 320,
    parameter int unsigned altura  = 240,
    parameter int unsigned fator   = 2,
    parameter int unsigned ADDR_W  = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_data,
    output logic [7:0]        pixel_out,
    output logic              pixel_valid,
    input  logic              pixel_ready,
    output logic              block_last,
    output logic              frame_last
);

`ifdef BLOCK_SCAN_PAD_EN
    localparam int unsigned NBX = (largura + fator - 1) / fator;
    localparam int unsigned NBY = (altura + fator - 1) / fator;
`else
    localparam int unsigned NBX = largura / fator;
    localparam int unsigned NBY = altura / fator;
`endif

    localparam int unsigned DW  = $clog2(fator + 1);
    localparam int unsigned BXW = $clog2(NBX + 1);
    localparam int unsigned BYW = $clog2(NBY + 1);
    // One extra bit so padded coordinates cannot wrap before being clamped.
    localparam int unsigned XW  = ADDR_W + 1;

    localparam logic [DW-1:0]  DMAX  = DW'(fator - 1);
    localparam logic [BXW-1:0] BXMAX = BXW'(NBX - 1);
    localparam logic [BYW-1:0] BYMAX = BYW'(NBY - 1);

    typedef enum logic [2:0] {StIdle, StRead, StCapture, StHold, StDone} state_t;

    state_t          state;
    logic [DW-1:0]   dx, dy, dx_n, dy_n, tdx, tdy;
    logic [BXW-1:0]  bx, bx_n, tbx;
    logic [BYW-1:0]  by, by_n, tby;
    logic [XW-1:0]   x, y;
    logic [ADDR_W-1:0] addr_n;
    logic            tile_end, frame_end;

    assign tile_end  = (dx == DMAX) && (dy == DMAX);
    assign frame_end = tile_end && (bx == BXMAX) && (by == BYMAX);

    always_comb begin
        dx_n = dx;
        dy_n = dy;
        bx_n = bx;
        by_n = by;
        if (dx != DMAX) begin
            dx_n = dx + 1'b1;
        end else begin
            dx_n = '0;
            if (dy != DMAX) begin
                dy_n = dy + 1'b1;
            end else begin
                dy_n = '0;
                if (bx != BXMAX) begin
                    bx_n = bx + 1'b1;
                end else begin
                    bx_n = '0;
                    by_n = (by == BYMAX) ? '0 : by + 1'b1;
                end
            end
        end
    end

    // In HOLD the next read targets the advanced position; elsewhere the current one.
    always_comb begin
        tdx = (state == StHold) ? dx_n : dx;
        tdy = (state == StHold) ? dy_n : dy;
        tbx = (state == StHold) ? bx_n : bx;
        tby = (state == StHold) ? by_n : by;
        x = XW'(tbx) * XW'(fator) + XW'(tdx);
        y = XW'(tby) * XW'(fator) + XW'(tdy);
`ifdef BLOCK_SCAN_PAD_EN
        if (x > XW'(largura - 1)) x = XW'(largura - 1);
        if (y > XW'(altura - 1))  y = XW'(altura - 1);
`endif
        addr_n = ADDR_W'(y) * ADDR_W'(largura) + ADDR_W'(x);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= StIdle;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_addr    <= '0;
            mem_rd_en   <= 1'b0;
            pixel_out   <= '0;
            pixel_valid <= 1'b0;
            block_last  <= 1'b0;
            frame_last  <= 1'b0;
            dx          <= '0;
            dy          <= '0;
            bx          <= '0;
            by          <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state     <= StRead;
                        busy      <= 1'b1;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= addr_n;
                    end
                end
                StRead: begin
                    mem_rd_en <= 1'b0;
                    state     <= StCapture;
                end
                StCapture: begin
                    pixel_out   <= mem_data;
                    pixel_valid <= 1'b1;
                    block_last  <= tile_end;
                    frame_last  <= frame_end;
                    state       <= StHold;
                end
                StHold: begin
                    if (pixel_ready) begin
                        pixel_valid <= 1'b0;
                        block_last  <= 1'b0;
                        frame_last  <= 1'b0;
                        dx          <= dx_n;
                        dy          <= dy_n;
                        bx          <= bx_n;
                        by          <= by_n;
                        if (frame_end) begin
                            state <= StDone;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state     <= StRead;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= addr_n;
                        end
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_block_scan_reader.sv
// Scoreboard bench for block_scan_reader: a 4x4 instance and a 5x2 (odd width) instance.
module tb_block_scan_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       a_start, a_busy, a_done, a_rd, a_valid, a_ready, a_bl, a_fl;
    logic [4:0] a_addr;
    logic [7:0] a_mdata, a_pix;

    logic       b_start, b_busy, b_done, b_rd, b_valid, b_ready, b_bl, b_fl;
    logic [3:0] b_addr;
    logic [7:0] b_mdata, b_pix;

    block_scan_reader #(.largura(4), .altura(4), .fator(2), .ADDR_W(5)) dut_a (
        .clk(clk), .reset(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
        .mem_addr(a_addr), .mem_rd_en(a_rd), .mem_data(a_mdata), .pixel_out(a_pix),
        .pixel_valid(a_valid), .pixel_ready(a_ready), .block_last(a_bl), .frame_last(a_fl)
    );

    block_scan_reader #(.largura(5), .altura(2), .fator(2), .ADDR_W(4)) dut_b (
        .clk(clk), .reset(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
        .mem_addr(b_addr), .mem_rd_en(b_rd), .mem_data(b_mdata), .pixel_out(b_pix),
        .pixel_valid(b_valid), .pixel_ready(b_ready), .block_last(b_bl), .frame_last(b_fl)
    );

    // Memory A holds mem[i] = i; memory B holds mem[i] = i + 100.
    always @(posedge clk) if (a_rd) a_mdata <= {3'b000, a_addr};
    always @(posedge clk) if (b_rd) b_mdata <= {4'b0000, b_addr} + 8'd100;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    int a_tab[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
`ifdef BLOCK_SCAN_PAD_EN
    int b_n = 12;
`else
    int b_n = 8;
`endif
    int b_tab[12] = '{0, 1, 5, 6, 2, 3, 7, 8, 4, 4, 9, 9};

    logic [9:0] qa[$];
    logic [9:0] qb[$];
    logic [9:0] e_a, e_b, prev_a, prev_b;
    bit hold_a = 0, hold_b = 0;
    int n_acc_a = 0, n_done_a = 0, n_acc_b = 0, n_done_b = 0;

    // Monitors: pop the next expected {pixel, block_last, frame_last} on every handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_a = 0;
        end else begin
            if (hold_a) chk("hold_stable_a", int'({a_pix, a_bl, a_fl}), int'(prev_a));
            if (a_valid) chk("busy_with_valid_a", int'(a_busy), 1);
            if (a_valid && !a_ready) chk("no_read_in_hold_a", int'(a_rd), 0);
            if (a_done) begin
                chk("busy_low_at_done_a", int'(a_busy), 0);
                n_done_a++;
            end
            if (a_valid && a_ready) begin
                if (qa.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_pixel_a: got pixel %0d, expected none", a_pix);
                end else begin
                    e_a = qa.pop_front();
                    chk($sformatf("pixel_a[%0d]", n_acc_a), int'({a_pix, a_bl, a_fl}), int'(e_a));
                end
                n_acc_a++;
            end
            hold_a = a_valid && !a_ready;
            prev_a = {a_pix, a_bl, a_fl};
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_b = 0;
        end else begin
            if (hold_b) chk("hold_stable_b", int'({b_pix, b_bl, b_fl}), int'(prev_b));
            if (b_done) begin
                chk("busy_low_at_done_b", int'(b_busy), 0);
                n_done_b++;
            end
            if (b_valid && b_ready) begin
                if (qb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_pixel_b: got pixel %0d, expected none", b_pix);
                end else begin
                    e_b = qb.pop_front();
                    chk($sformatf("pixel_b[%0d]", n_acc_b), int'({b_pix, b_bl, b_fl}), int'(e_b));
                end
                n_acc_b++;
            end
            hold_b = b_valid && !b_ready;
            prev_b = {b_pix, b_bl, b_fl};
        end
    end

    task automatic chk_a_zero(input string tag);
        chk({tag, "_busy"}, int'(a_busy), 0);
        chk({tag, "_done"}, int'(a_done), 0);
        chk({tag, "_rd_en"}, int'(a_rd), 0);
        chk({tag, "_addr"}, int'(a_addr), 0);
        chk({tag, "_pixel"}, int'(a_pix), 0);
        chk({tag, "_valid"}, int'(a_valid), 0);
        chk({tag, "_block_last"}, int'(a_bl), 0);
        chk({tag, "_frame_last"}, int'(a_fl), 0);
    endtask

    task automatic run_a(input bit bp, input bit mid_start, input int abort_at);
        int d0;
        bit did;
        qa.delete();
        for (int i = 0; i < 16; i++) qa.push_back({8'(a_tab[i]), (i % 4) == 3, i == 15});
        n_acc_a = 0;
        d0 = n_done_a;
        did = 0;
        a_ready = 1;
        @(posedge clk); #1 a_start = 1;
        @(posedge clk); #1 a_start = 0;
        chk("lat_c1_rd_en", int'(a_rd), 1);
        chk("lat_c1_addr", int'(a_addr), 0);
        chk("lat_c1_busy", int'(a_busy), 1);
        chk("lat_c1_valid", int'(a_valid), 0);
        @(posedge clk); #1;
        chk("lat_c2_valid", int'(a_valid), 0);
        chk("lat_c2_rd_en", int'(a_rd), 0);
        @(posedge clk); #1;
        chk("lat_c3_valid", int'(a_valid), 1);
        for (int c = 0; c < 600 && n_done_a == d0; c++) begin
            if (mid_start && !did && n_acc_a == 7) begin
                a_start = 1;
                did = 1;
            end else begin
                a_start = 0;
            end
            if (bp && !did && n_acc_a == 1) begin
                a_ready = 0;
                for (int k = 0; k < 10 && !a_valid; k++) begin @(posedge clk); #1; end
                repeat (5) begin
                    chk("bp_pixel", int'(a_pix), 1);
                    chk("bp_valid", int'(a_valid), 1);
                    chk("bp_rd_en", int'(a_rd), 0);
                    @(posedge clk); #1;
                end
                a_ready = 1;
                did = 1;
            end
            if (abort_at != 0 && n_acc_a == abort_at) begin
                a_ready = 0;
                for (int k = 0; k < 10 && !a_valid; k++) begin @(posedge clk); #1; end
                chk("abort_valid_before_reset", int'(a_valid), 1);
                @(posedge clk); #2;
                rst_n = 0;
                #1;
                chk_a_zero("mid_reset");
                qa.delete();
                @(posedge clk); #1;
                rst_n = 1;
                a_ready = 1;
                return;
            end
            @(posedge clk); #1;
        end
        a_start = 0;
        repeat (8) @(posedge clk);
        #1;
        chk("done_pulses_a", n_done_a - d0, 1);
        chk("pixels_a", n_acc_a, 16);
        chk("queue_empty_a", qa.size(), 0);
    endtask

    task automatic run_b();
        int d0;
        qb.delete();
        for (int i = 0; i < b_n; i++) qb.push_back({8'(b_tab[i] + 100), (i % 4) == 3, i == b_n - 1});
        n_acc_b = 0;
        d0 = n_done_b;
        b_ready = 1;
        @(posedge clk); #1 b_start = 1;
        @(posedge clk); #1 b_start = 0;
        for (int c = 0; c < 600 && n_done_b == d0; c++) begin @(posedge clk); #1; end
        repeat (8) @(posedge clk);
        #1;
        chk("done_pulses_b", n_done_b - d0, 1);
        chk("pixels_b", n_acc_b, b_n);
        chk("queue_empty_b", qb.size(), 0);
    endtask

    initial begin
        rst_n = 0;
        a_start = 0;
        b_start = 0;
        a_ready = 1;
        b_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk_a_zero("reset");
        chk("reset_b_busy", int'(b_busy), 0);
        chk("reset_b_valid", int'(b_valid), 0);
        chk("reset_b_addr", int'(b_addr), 0);
        rst_n = 1;
        run_a(0, 0, 0);
        run_a(1, 0, 0);
        run_a(0, 1, 0);
        run_a(0, 0, 5);
        run_a(0, 0, 0);
        run_b();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/block_scan_reader.md
# block_scan_reader

Upstream feeder for the block-averaging stage. Reads a source frame of `largura` x `altura` 8-bit pixels from a synchronous single-port memory and emits the pixels in block-major order: all `fator` x `fator` pixels of one tile, row by row, then the next tile left to right, then the next tile row. Output is a valid/ready stream with per-block and per-frame markers, so the downstream averager sees each tile's pixels back to back.

## Interface
- `largura`, 320: frame width in pixels.
- `altura`, 240: frame height in pixels.
- `fator`, 2: tile edge length in pixels; must be ≥ 1.
- `ADDR_W`, 17: memory address width; must satisfy 2^ADDR_W ≥ largura*altura.

- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low; asserted while low, released synchronously to `clk`.
- `start`  in  1  starts a frame scan; sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE.
- `done`  out  1  one-cycle pulse after the last pixel's handshake.
- `mem_addr`  out  ADDR_W  linear read address = y*largura + x.
- `mem_rd_en`  out  1  read strobe.
- `mem_data`  in  8  read data, valid exactly one cycle after `mem_rd_en`.
- `pixel_out`  out  8  output pixel.
- `pixel_valid`  out  1  `pixel_out` holds a pixel.
- `pixel_ready`  in  1  downstream accepts the pixel.
- `block_last`  out  1  qualifies the last pixel of a tile.
- `frame_last`  out  1  qualifies the last pixel of the frame.

## Operation
- Counters: `dx`, `dy` (0..fator-1, position in tile); `bx`, `by` (tile column and row). Coordinates: x = bx*fator + dx; y = by*fator + dy.
- Scan order: `dx` fastest, then `dy`, then `bx`, then `by`. Each counter wraps to 0 when it passes its maximum and carries into the next counter.
- Tile counts: NBX = largura/fator and NBY = altura/fator, using integer floor division. Partial edge tiles are skipped (see Configuration).
- FSM states:
  - IDLE: goes to READ when `start`=1.
  - READ: drives `mem_addr` and `mem_rd_en`=1; goes to CAPTURE.
  - CAPTURE: loads `mem_data` into `pixel_out`, sets `pixel_valid`; goes to HOLD.
  - HOLD: stays while `pixel_ready`=0. On handshake, clears `pixel_valid` and advances the counters; goes to DONE if this was the last pixel, else READ.
  - DONE: `done`=1 for one cycle; goes to IDLE.
- `block_last` = (dx==fator-1 && dy==fator-1), registered alongside `pixel_out`. `frame_last` = `block_last` && bx==NBX-1 && by==NBY-1.
- `mem_addr` is computed in full width without truncation. The product y*largura is formed at least ADDR_W bits wide.
- `start` is ignored in every state except IDLE.
- All counters are 0 in IDLE; each frame restarts from tile (0,0).

## Timing
- Reset values: `busy`, `done`, `mem_rd_en`, `pixel_valid`, `block_last` and `frame_last` are 0; `mem_addr` = 0; `pixel_out` = 0; FSM in IDLE; all counters 0.
- Cycle numbering: `start` is sampled high at edge 0.
  - Cycle 1: READ, with `mem_addr` and `mem_rd_en` driven.
  - Cycle 2: CAPTURE.
  - Cycle 3: `pixel_valid`=1.
- Throughput: one pixel per 3 cycles when `pixel_ready` is held high.
- While `pixel_valid`=1 and `pixel_ready`=0: `pixel_out`, `block_last` and `frame_last` hold stable, and `mem_rd_en`=0.
- The `done` pulse occurs in the cycle after the final handshake. `busy` falls in that same cycle.
- Reset asserted mid-scan: all outputs return to reset values immediately, the partial frame is abandoned, and the next `start` scans from (0,0).
- `pixel_ready` arriving with no valid pixel has no effect.

## Configuration
- `BLOCK_SCAN_PAD_EN` defined:
  - NBX = ceil(largura/fator) and NBY = ceil(altura/fator).
  - Coordinates beyond the frame are clamped to largura-1 / altura-1 (edge replication), so every tile emits exactly fator*fator pixels.
- `BLOCK_SCAN_PAD_EN` undefined: floor counts; the rightmost columns and bottom rows that do not fill a tile are never read.
- When largura and altura are multiples of `fator`, both builds behave identically.

## Test plan
- Basic scan. Setup: largura=4, altura=4, fator=2, memory[i]=i, `pixel_ready`=1. Required: addresses 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15; `pixel_out` equals each address; `block_last` on every 4th pixel; `frame_last` only on 15; one `done` pulse.
- Backpressure. Stimulus: hold `pixel_ready`=0 for 5 cycles on the 2nd pixel. Required: `pixel_out`=1 stable throughout, no `mem_rd_en`, and the sequence resumes with 4 and no pixel lost or duplicated.
- Odd width. Setup: largura=5, altura=2, fator=2.
  - Without the macro: 8 pixels (addresses 0,1,5,6,2,3,7,8).
  - With `BLOCK_SCAN_PAD_EN`: 12 pixels, the third tile being addresses 4,4,9,9.
- Reset mid-scan. Stimulus: drive `reset` low during the 6th pixel's HOLD. Required: all outputs return to 0 at once; after release, a new `start` begins at address 0.
- Start while busy. Stimulus: pulse `start` during a scan. Required: ignored; exactly 16 pixels and one `done`.
- Latency check. Stimulus: `start` at edge 0. Required: `mem_rd_en` high in cycle 1, first `pixel_valid` in cycle 3, `busy` high in cycles 1 through the last HOLD.
